// File: rtl/encoder83_pkg.sv
// encoder83_pkg: shared widths and constants for the registered 8-to-3 priority encoder.
package encoder83_pkg;
   localparam int IN_W  = 8;
   localparam int OUT_W = 3;
   localparam logic [OUT_W-1:0] IDX_NONE = 3'd0;
endpackage

// File: rtl/encoder83_prio_comb.sv
// encoder83_prio_comb: combinational priority core; multi-hot flag present only with ENCODER83_ONEHOT_CHK_EN.
module encoder83_prio_comb
   import encoder83_pkg::*;
#(
   parameter bit PRIORITY_MSB = 1'b1
) (
   input  logic [IN_W-1:0]  iData,
   output logic [OUT_W-1:0] idx_o,
   output logic             any_o
`ifdef ENCODER83_ONEHOT_CHK_EN
   ,
   output logic             multi_o
`endif
);
   // The scan runs toward the winning end, so the last set bit seen has priority.
   always_comb begin
      idx_o = IDX_NONE;
      for (int k = 0; k < IN_W; k++)
         if (PRIORITY_MSB ? iData[k] : iData[IN_W-1-k])
            idx_o = PRIORITY_MSB ? OUT_W'(k) : OUT_W'(IN_W-1-k);
   end
   assign any_o = |iData;
`ifdef ENCODER83_ONEHOT_CHK_EN
   assign multi_o = (iData & (iData - IN_W'(1))) != '0;
`endif
endmodule

// File: rtl/encoder_83.sv
// encoder_83: registered 8-to-3 priority encoder with capture enable.
// Optional oErr multi-hot flag is compiled in with ENCODER83_ONEHOT_CHK_EN.
module encoder_83
   import encoder83_pkg::*;
#(
   parameter bit PRIORITY_MSB = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             iEn,
   input  logic [IN_W-1:0]  iData,
   output logic [OUT_W-1:0] oData,
   output logic             oValid
`ifdef ENCODER83_ONEHOT_CHK_EN
   ,
   output logic             oErr
`endif
);
   logic [OUT_W-1:0] data_d, data_q;
   logic             valid_d, valid_q;
`ifdef ENCODER83_ONEHOT_CHK_EN
   logic             err_d, err_q;
`endif
   encoder83_prio_comb #(.PRIORITY_MSB(PRIORITY_MSB)) u_core (
      .iData  (iData),
      .idx_o  (data_d),
      .any_o  (valid_d)
`ifdef ENCODER83_ONEHOT_CHK_EN
      ,
      .multi_o(err_d)
`endif
   );
   always_ff @(posedge clk)
      if (!rst_n) begin
         data_q  <= IDX_NONE;
         valid_q <= 1'b0;
      end else if (iEn) begin
         data_q  <= data_d;
         valid_q <= valid_d;
      end
   assign oData  = data_q;
   assign oValid = valid_q;
`ifdef ENCODER83_ONEHOT_CHK_EN
   always_ff @(posedge clk)
      if (!rst_n) err_q <= 1'b0;
      else if (iEn) err_q <= err_d;
   assign oErr = err_q;
`endif
endmodule

// File: tb/tb_encoder_83.sv
// tb_encoder_83: scoreboard bench for encoder_83, MSB- and LSB-priority instances side by side.
module tb_encoder_83;
   logic       clk = 1'b0;
   logic       rst_n;
   logic       iEn;
   logic [7:0] iData;
   logic [2:0] m_data, l_data;
   logic       m_valid, l_valid;
`ifdef ENCODER83_ONEHOT_CHK_EN
   logic       m_err, l_err;
`endif
   typedef struct {
      logic [7:0] d;
      logic [2:0] em;
      logic [2:0] el;
      logic       ev;
      logic       ee;
   } exp_t;
   exp_t exp_q[$];
   int   n_vec = 0;
   int   n_bad = 0;
   bit   drv_done = 1'b0;

   always #5 clk = ~clk;

   encoder_83 #(.PRIORITY_MSB(1'b1)) u_msb (
      .clk(clk), .rst_n(rst_n), .iEn(iEn), .iData(iData),
      .oData(m_data), .oValid(m_valid)
`ifdef ENCODER83_ONEHOT_CHK_EN
      , .oErr(m_err)
`endif
   );
   encoder_83 #(.PRIORITY_MSB(1'b0)) u_lsb (
      .clk(clk), .rst_n(rst_n), .iEn(iEn), .iData(iData),
      .oData(l_data), .oValid(l_valid)
`ifdef ENCODER83_ONEHOT_CHK_EN
      , .oErr(l_err)
`endif
   );

   task automatic run(input logic r, input logic en, input logic [7:0] d, input int reps,
                      input logic [2:0] em, input logic [2:0] el, input logic ev, input logic ee);
      exp_t e;
      e = '{d: d, em: em, el: el, ev: ev, ee: ee};
      for (int i = 0; i < reps; i++) begin
         rst_n = r;
         iEn   = en;
         iData = d;
         @(posedge clk);
         exp_q.push_back(e);
         #1;
      end
   endtask

   // Monitor: outputs are registered, so every edge presents a new result to check.
   always @(negedge clk)
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         n_vec++;
         if (m_data !== e.em || m_valid !== e.ev) begin
            n_bad++;
            $display("FAIL msb d=%h: got data=%0d valid=%b, want data=%0d valid=%b", e.d, m_data, m_valid, e.em, e.ev);
         end
         if (l_data !== e.el || l_valid !== e.ev) begin
            n_bad++;
            $display("FAIL lsb d=%h: got data=%0d valid=%b, want data=%0d valid=%b", e.d, l_data, l_valid, e.el, e.ev);
         end
`ifdef ENCODER83_ONEHOT_CHK_EN
         if (m_err !== e.ee || l_err !== e.ee) begin
            n_bad++;
            $display("FAIL err d=%h: got msb=%b lsb=%b, want %b", e.d, m_err, l_err, e.ee);
         end
`endif
      end

   initial begin
      rst_n = 1'b0;
      iEn   = 1'b0;
      iData = 8'h00;
      //   rst  en   data  n  msb   lsb   v     err
      run(1'b0, 1'b1, 8'hFF, 2, 3'd0, 3'd0, 1'b0, 1'b0);
      run(1'b1, 1'b1, 8'h80, 4, 3'd7, 3'd7, 1'b1, 1'b0);
      run(1'b1, 1'b1, 8'h40, 4, 3'd6, 3'd6, 1'b1, 1'b0);
      run(1'b1, 1'b1, 8'h20, 4, 3'd5, 3'd5, 1'b1, 1'b0);
      run(1'b1, 1'b1, 8'h10, 4, 3'd4, 3'd4, 1'b1, 1'b0);
      run(1'b1, 1'b1, 8'h08, 4, 3'd3, 3'd3, 1'b1, 1'b0);
      run(1'b1, 1'b1, 8'h04, 4, 3'd2, 3'd2, 1'b1, 1'b0);
      run(1'b1, 1'b1, 8'h02, 4, 3'd1, 3'd1, 1'b1, 1'b0);
      run(1'b1, 1'b1, 8'h01, 4, 3'd0, 3'd0, 1'b1, 1'b0);
      run(1'b1, 1'b1, 8'h00, 2, 3'd0, 3'd0, 1'b0, 1'b0);
      run(1'b1, 1'b1, 8'h01, 1, 3'd0, 3'd0, 1'b1, 1'b0);
      run(1'b1, 1'b1, 8'h52, 2, 3'd6, 3'd1, 1'b1, 1'b1);
      run(1'b1, 1'b1, 8'hFF, 1, 3'd7, 3'd0, 1'b1, 1'b1);
      run(1'b1, 1'b1, 8'h03, 1, 3'd1, 3'd0, 1'b1, 1'b1);
      run(1'b1, 1'b1, 8'hC0, 1, 3'd7, 3'd6, 1'b1, 1'b1);
      run(1'b1, 1'b1, 8'h20, 1, 3'd5, 3'd5, 1'b1, 1'b0);
      run(1'b1, 1'b0, 8'h02, 3, 3'd5, 3'd5, 1'b1, 1'b0);
      run(1'b1, 1'b1, 8'h02, 1, 3'd1, 3'd1, 1'b1, 1'b0);
      run(1'b1, 1'b1, 8'h52, 1, 3'd6, 3'd1, 1'b1, 1'b1);
      run(1'b1, 1'b0, 8'h00, 2, 3'd6, 3'd1, 1'b1, 1'b1);
      run(1'b1, 1'b1, 8'h80, 2, 3'd7, 3'd7, 1'b1, 1'b0);
      run(1'b0, 1'b1, 8'h80, 1, 3'd0, 3'd0, 1'b0, 1'b0);
      run(1'b1, 1'b1, 8'h80, 1, 3'd7, 3'd7, 1'b1, 1'b0);
      run(1'b1, 1'b1, 8'h81, 1, 3'd7, 3'd0, 1'b1, 1'b1);
      run(1'b0, 1'b0, 8'h81, 1, 3'd0, 3'd0, 1'b0, 1'b0);
      run(1'b1, 1'b0, 8'h81, 1, 3'd0, 3'd0, 1'b0, 1'b0);
      drv_done = 1'b1;
   end

   initial begin
      wait (drv_done);
      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
      #1;
      if (exp_q.size() > 0) begin
         n_bad++;
         $display("FAIL drain: %0d expected results never checked, want 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish, want finish before 100000");
      $fatal(1);
   end
endmodule
